// File: rtl/pri_enc_rr_queue.sv
// Registered priority encoder. Requests are captured into a sticky pending register.
// A one-entry valid/ready slot issues one granted index per handshake, in fixed or round-robin order.
module pri_enc_rr_queue #(
    parameter int N  = 8,
    parameter int RR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         out_onehot,
    output logic [N-1:0]         pending,
    output logic                 any_pend
);
    localparam int W = $clog2(N);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;

    logic         hs;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    logic         sel_found;
    logic [W-1:0] sel_idx;
    int           cand;

    // Valid/ready: a grant transfers on a cycle where out_valid and out_ready are both high;
    // while out_valid is high and out_ready low, the slot contents are frozen.
    assign hs   = valid_q & out_ready;
    assign clr  = hs ? onehot_q : '0;
    assign elig = pend_q & mask & ~clr;

    // The last assignment in each loop wins, so it is the highest-priority candidate.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        if (RR != 0) begin
            for (int k = N; k >= 1; k--) begin
                cand = (int'(ptr_q) + N - k) % N;
                if (elig[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = W'(cand);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = W'(i);
                end
            end
        end
    end

    always_comb begin
        pend_d   = (pend_q & ~clr) | (en ? req : '0);
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (!valid_q || hs) begin
            valid_d = sel_found;
            if (sel_found) begin
                idx_d           = sel_idx;
                ptr_d           = sel_idx;
                onehot_d        = '0;
                onehot_d[sel_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= '0;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign pending    = pend_q;
    assign any_pend   = |pend_q;
endmodule

// File: doc/pri_enc_rr_queue.md
# pri_enc_rr_queue

Parametrised, registered priority encoder with sticky request capture, per-line masking, selectable fixed or round-robin priority, and a valid/ready output slot. It turns an N-bit request vector into a stream of granted indices, one per handshake. It sits between raw request or interrupt lines and a consumer that services one index at a time.

## Interface

Parameters:
- `N`, 8: number of request lines; legal range 2..64.
- `RR`, 0: priority mode.
  - 0 = fixed priority; the highest index wins.
  - 1 = round-robin.
- `W`, `$clog2(N)`: derived localparam giving the index width. Not overridable.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  request sampling enable.
- `req`  in  N  request lines; bit i requests index i.
- `mask`  in  N  1 = line eligible for selection, 0 = held pending but not selectable.
- `out_ready`  in  1  consumer accepts `out_idx` this cycle.
- `out_valid`  out  1  output slot holds a grant.
- `out_idx`  out  W  granted index.
- `out_onehot`  out  N  one-hot form of `out_idx`.
- `pending`  out  N  current sticky pending register.
- `any_pend`  out  1  OR-reduction of `pending`.

## Operation

Handshake:
- `hs` = `out_valid & out_ready`.
- `clr` = `hs ? out_onehot : 0`.

Pending register:
- `pend_next = (pend & ~clr) | (en ? req : 0)`.
- If a bit is set and cleared in the same cycle, set wins.

Eligible set:
- `elig = pend & mask & ~clr`.
- This excludes the grant being accepted this cycle, so it is never issued twice.

Output slot load condition:
- The slot loads when `!out_valid | hs`.
- On load, `out_valid <= |elig`.
- If `elig` ≠ 0, `out_idx` and `out_onehot` take the selected index and `ptr` is updated.

Hold rule:
- While `out_valid=1` and `out_ready=0`, `out_idx` and `out_onehot` are frozen.
- Changes to `mask` or `pend` do not withdraw or alter an issued grant.

Selection, fixed mode (`RR=0`):
- The highest set index of `elig` wins (N-1 > … > 0).

Selection, round-robin mode (`RR=1`):
- `ptr` (W bits) holds the last loaded index.
- Search order is descending from `ptr-1`, wrapping from 0 to N-1, ending at `ptr`.
- Wrap is modulo N, so non-power-of-two N never yields an index ≥ N.
- Reset `ptr=0` gives a first search order of N-1..0, which is identical to fixed mode.

Reset values (`rst_n=0` at an edge):
- `pend=0`, `ptr=0`, `out_valid=0`, `out_idx=0`, `out_onehot=0`.
- Consequently `pending=0` and `any_pend=0`.
- Reset mid-operation drops the held grant and all pending requests, with no handshake.

Derived output:
- `any_pend` is combinational from the `pend` register.

## Timing

Latency:
- A `req` bit sampled at edge T is visible in `pending` after T.
- With the slot empty, `out_valid` is asserted after edge T+1, giving 2-cycle req→grant latency.

Throughput:
- One grant per cycle while `out_ready=1` and `elig≠0`.
- A bit accepted at edge T is reissued no earlier than edge T+1, and only if it is set again.

Boundary conditions:
- Empty `elig` at a load: `out_valid` goes 0; `out_idx` and `out_onehot` keep their last values and are don't-care.
- Masked pending bits stay in `pending` indefinitely; `any_pend` stays 1.
- With `en=0`, `req` is ignored and pending bits still drain normally.

## Test plan

1. Reset: hold `rst_n=0` for 2 cycles with `req=8'hFF`, `en=1` → `pending=0`, `out_valid=0`, `out_idx=0`, `out_onehot=0`, `any_pend=0`.
2. Fixed mode (N=8, RR=0): single-cycle pulse `req=8'h2C`, `mask=8'hFF`, `out_ready=1` → `out_idx` 5, 3, 2 on three consecutive cycles starting 2 cycles after the pulse; then `out_valid=0`, `pending=0`.
3. Backpressure: pulse `req=8'h81`, `out_ready=0` → `out_idx=7` and `out_onehot=8'h80` stable for 10 cycles with `pending=8'h81`; raise `out_ready` → 7 accepted, then 0 next cycle, then `out_valid=0`.
4. Mode contrast: `req=8'hFF` held, `en=1`, `out_ready=1`:
   - RR=1 → grants 7,6,5,4,3,2,1,0,7,…
   - RR=0 → grants alternate 7,6,7,6,…
5. Mask and non-power-of-two wrap (N=5, RR=1): pulse `req=5'b10001`, `mask=5'b00001` → only index 0 granted; then `pending=5'b10000`, `any_pend=1`, `out_valid=0`. Set `mask=5'b11111` → index 4 granted, and no index ≥5 ever appears.
6. Simultaneous set/clear: assert `req[3]` in the handshake cycle of index 3 → `pending[3]` stays 1 and index 3 is granted again on a later cycle. Then assert `rst_n=0` while `out_valid=1` → all outputs 0 at the next edge.
